// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters, with one-deep response slots and a
//            saturating contention counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ALUCTRL_WIDTH-1:0] req0_ctrl,
  input  logic [DATA_WIDTH-1:0]    req0_op1,
  input  logic [DATA_WIDTH-1:0]    req0_op2,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ALUCTRL_WIDTH-1:0] req1_ctrl,
  input  logic [DATA_WIDTH-1:0]    req1_op1,
  input  logic [DATA_WIDTH-1:0]    req1_op2,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_sum,
  output logic                     rsp0_zero,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_sum,
  output logic                     rsp1_zero,
  output logic [ALUCTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0]    alu_op1,
  output logic [DATA_WIDTH-1:0]    alu_op2,
  input  logic [DATA_WIDTH-1:0]    alu_sum,
  input  logic                     alu_zero,
  output logic [CNT_WIDTH-1:0]     conflict_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  r_last;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_sum;
  logic [DATA_WIDTH-1:0] r_rsp1_sum;
  logic                  r_rsp0_zero;
  logic                  r_rsp1_zero;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_contend;

  // A slot being drained this cycle can accept a new result at the same edge.
  assign w_elig0 = req0_valid & (~r_rsp0_valid | rsp0_ready);
  assign w_elig1 = req1_valid & (~r_rsp1_valid | rsp1_ready);

  // r_last = 1 means requester 1 was granted last, so requester 0 wins a tie.
  assign w_gnt0 = w_elig0 & (~w_elig1 | r_last);
  assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last);

  assign w_contend = req0_valid & req1_valid & ~(w_gnt0 & w_gnt1);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    alu_ctrl = '0;
    alu_op1  = '0;
    alu_op2  = '0;
    if (w_gnt0) begin
      alu_ctrl = req0_ctrl;
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
    end else if (w_gnt1) begin
      alu_ctrl = req1_ctrl;
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_sum   <= '0;
      r_rsp0_zero  <= 1'b0;
    end else if (w_gnt0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_sum   <= alu_sum;
      r_rsp0_zero  <= alu_zero;
    end else if (rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_sum   <= '0;
      r_rsp1_zero  <= 1'b0;
    end else if (w_gnt1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_sum   <= alu_sum;
      r_rsp1_zero  <= alu_zero;
    end else if (rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_contend && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign rsp0_valid   = r_rsp0_valid;
  assign rsp0_sum     = r_rsp0_sum;
  assign rsp0_zero    = r_rsp0_zero;
  assign rsp1_valid   = r_rsp1_valid;
  assign rsp1_sum     = r_rsp1_sum;
  assign rsp1_zero    = r_rsp1_zero;
  assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a small ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [CW-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_sum, rsp1_sum, alu_op1, alu_op2, alu_sum;
  logic          rsp0_zero, rsp1_zero, alu_zero;
  logic [KW-1:0] conflict_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .ALUCTRL_WIDTH(CW), .CNT_WIDTH(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
    .rsp1_zero(rsp1_zero),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sum(alu_sum), .alu_zero(alu_zero), .conflict_cnt(conflict_cnt)
  );

  // Shared ALU model; undefined opcodes return 0.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_sum = alu_op1 + alu_op2;
      4'b1000: alu_sum = alu_op1 - alu_op2;
      4'b0110: alu_sum = alu_op1 | alu_op2;
      4'b0111: alu_sum = alu_op1 & alu_op2;
      4'b0001: alu_sum = alu_op1 << alu_op2[4:0];
      4'b0101: alu_sum = alu_op1 >> alu_op2[4:0];
      default: alu_sum = '0;
    endcase
    alu_zero = (alu_sum == '0);
  end

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    req0_ctrl = 0; req0_op1 = 0; req0_op2 = 0;
    req1_ctrl = 0; req1_op1 = 0; req1_op2 = 0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    total_cnt++; if (rsp0_valid !== 1'b0) $display("FAIL reset_rsp0_valid: got %b expected 0", rsp0_valid); else pass_cnt++;
    total_cnt++; if (rsp1_valid !== 1'b0) $display("FAIL reset_rsp1_valid: got %b expected 0", rsp1_valid); else pass_cnt++;
    total_cnt++; if (rsp0_sum !== 32'd0 || rsp0_zero !== 1'b0) $display("FAIL reset_rsp0_data: got %0h/%b expected 0/0", rsp0_sum, rsp0_zero); else pass_cnt++;
    total_cnt++; if (rsp1_sum !== 32'd0 || rsp1_zero !== 1'b0) $display("FAIL reset_rsp1_data: got %0h/%b expected 0/0", rsp1_sum, rsp1_zero); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL idle_ready: got %b%b expected 00", req0_ready, req1_ready); else pass_cnt++;
    total_cnt++; if (alu_ctrl !== 4'd0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0) $display("FAIL idle_alu_drive: got %0h %0h %0h expected 0 0 0", alu_ctrl, alu_op1, alu_op2); else pass_cnt++;
  endtask

  task automatic test_single_issue();
    rsp0_ready = 0;
    req0_valid = 1; req0_ctrl = 4'b0000; req0_op1 = 5; req0_op2 = 7;
    #1;
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready); else pass_cnt++;
    total_cnt++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) $display("FAIL single_alu_ops: got %0d %0d expected 5 7", alu_op1, alu_op2); else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 0;
    total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'd12 || rsp0_zero !== 1'b0) $display("FAIL single_rsp0: got %b %0d %b expected 1 12 0", rsp0_valid, rsp0_sum, rsp0_zero); else pass_cnt++;
    total_cnt++; if (rsp1_valid !== 1'b0 || conflict_cnt !== 4'd0) $display("FAIL single_idle_ch1: got %b %0d expected 0 0", rsp1_valid, conflict_cnt); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b1) $display("FAIL single_hold: got %b expected 1", rsp0_valid); else pass_cnt++;
    rsp0_ready = 1;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b0 || rsp0_sum !== 32'd12) $display("FAIL single_drain_stale: got %b %0d expected 0 12", rsp0_valid, rsp0_sum); else pass_cnt++;
  endtask

  task automatic test_tie_break();
    reset_pulse();
    req0_valid = 1; req0_ctrl = 4'b1000; req0_op1 = 9; req0_op2 = 9;
    req1_valid = 1; req1_ctrl = 4'b0000; req1_op1 = 1; req1_op2 = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) $display("FAIL tie_grant%0d: got %b%b expected %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); else pass_cnt++;
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'd0 || rsp0_zero !== 1'b1) $display("FAIL tie_rsp0_%0d: got %b %0h %b expected 1 0 1", i, rsp0_valid, rsp0_sum, rsp0_zero); else pass_cnt++;
      end else begin
        total_cnt++; if (rsp1_valid !== 1'b1 || rsp1_sum !== 32'd3 || rsp1_zero !== 1'b0) $display("FAIL tie_rsp1_%0d: got %b %0h %b expected 1 3 0", i, rsp1_valid, rsp1_sum, rsp1_zero); else pass_cnt++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    total_cnt++; if (conflict_cnt !== 4'd4) $display("FAIL tie_cnt: got %0d expected 4", conflict_cnt); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    rsp0_ready = 0;
    req0_valid = 1; req0_ctrl = 4'b0000; req0_op1 = 2; req0_op2 = 3;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'd5) $display("FAIL bp_fill: got %b %0d expected 1 5", rsp0_valid, rsp0_sum); else pass_cnt++;
    req0_op1 = 10; req0_op2 = 20;
    req1_valid = 1; req1_ctrl = 4'b0110; req1_op1 = 32'hF0; req1_op2 = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) $display("FAIL bp_grant%0d: got %b%b expected 01", i, req0_ready, req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (rsp1_valid !== 1'b1 || rsp1_sum !== 32'hFF || rsp0_sum !== 32'd5 || rsp0_valid !== 1'b1) $display("FAIL bp_rsp%0d: got %b %0h %0d %b expected 1 ff 5 1", i, rsp1_valid, rsp1_sum, rsp0_sum, rsp0_valid); else pass_cnt++;
    end
    rsp0_ready = 1;
    #1;
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL bp_release: got %b%b expected 10", req0_ready, req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    total_cnt++; if (rsp0_sum !== 32'd30 || conflict_cnt !== 4'd8) $display("FAIL bp_after: got %0d %0d expected 30 8", rsp0_sum, conflict_cnt); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_drain_refill();
    rsp0_ready = 1;
    req0_valid = 1; req0_ctrl = 4'b0001; req0_op1 = 1; req0_op2 = 4;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'd16) $display("FAIL refill_first: got %b %0d expected 1 16", rsp0_valid, rsp0_sum); else pass_cnt++;
    req0_ctrl = 4'b0101; req0_op1 = 32'h80; req0_op2 = 3;
    #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL refill_ready: got %b expected 1", req0_ready); else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 0;
    total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'h10 || rsp0_zero !== 1'b0) $display("FAIL refill_second: got %b %0h %b expected 1 10 0", rsp0_valid, rsp0_sum, rsp0_zero); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b0) $display("FAIL refill_drain: got %b expected 0", rsp0_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rsp1_ready = 0;
    req1_valid = 1; req1_ctrl = 4'b0000; req1_op1 = 1; req1_op2 = 1;
    @(posedge clk); #1;
    req1_valid = 0;
    total_cnt++; if (rsp1_valid !== 1'b1 || rsp1_sum !== 32'd2) $display("FAIL mid_fill: got %b %0d expected 1 2", rsp1_valid, rsp1_sum); else pass_cnt++;
    rsp0_ready = 0;
    req0_valid = 1; req0_ctrl = 4'b0000; req0_op1 = 4; req0_op2 = 4;
    #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL mid_accept: got %b expected 1", req0_ready); else pass_cnt++;
    #2;
    rst_n = 0;
    #1;
    total_cnt++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp1_sum !== 32'd0 || rsp0_sum !== 32'd0 || conflict_cnt !== 4'd0) $display("FAIL mid_async: got %b %b %0d %0d %0d expected 0 0 0 0 0", rsp0_valid, rsp1_valid, rsp1_sum, rsp0_sum, conflict_cnt); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rsp0_valid !== 1'b0 || rsp0_sum !== 32'd0) $display("FAIL mid_no_rsp: got %b %0d expected 0 0", rsp0_valid, rsp0_sum); else pass_cnt++;
    rsp0_ready = 1; rsp1_ready = 1;
    req1_valid = 1;
    rst_n = 1;
    #1;
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL mid_first_tie: got %b%b expected 10", req0_ready, req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 32'd8) $display("FAIL mid_after: got %b %0d expected 1 8", rsp0_valid, rsp0_sum); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [KW-1:0] exp_cnt;
    reset_pulse();
    req0_valid = 1; req0_ctrl = 4'b0000; req0_op1 = 1; req0_op2 = 1;
    req1_valid = 1; req1_ctrl = 4'b0000; req1_op1 = 2; req1_op2 = 2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      total_cnt++; if (conflict_cnt !== exp_cnt) $display("FAIL sat_cnt%0d: got %0d expected %0d", i, conflict_cnt, exp_cnt); else pass_cnt++;
    end
    idle_inputs();
    @(posedge clk); #1;
    total_cnt++; if (conflict_cnt !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", conflict_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_tie_break();
    test_back_pressure();
    test_drain_refill();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
